// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and arithmetic helpers for the FIR MAC engine
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Accumulator width: full product plus log2(DEPTH) guard bits, so the sum cannot overflow
  function automatic int acc_width(input int width, input int coef_width, input int depth);
    return width + coef_width + $clog2(depth);
  endfunction

  // Round half up, arithmetic shift, then clamp to a signed 'width'-bit range.
  // Operates on a 64-bit container, so the accumulator must be narrower than 64 bits.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] a,
                                                   input int frac_bits,
                                                   input int width);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (a + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/round_sat.sv
// rtl/round_sat.sv - combinational rounding and saturation of the accumulator to sample width
module round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W     = 37,
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic [ACC_W-1:0] acc,
  output logic [WIDTH-1:0] dout
);

  logic signed [ACC_W-1:0] acc_s;

  assign acc_s = acc;
  // The clamp guarantees the result fits in WIDTH bits, so truncation is lossless
  assign dout  = WIDTH'(sat_round(64'(acc_s), FRAC_BITS, WIDTH));

endmodule

// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - time-multiplexed FIR dot product, one MAC per cycle, valid/ready output
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 32,
  parameter int COEF_WIDTH = 16,
  parameter int FRAC_BITS  = 15
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DEPTH-1:0][WIDTH-1:0]      taps,
  input  logic [DEPTH-1:0][COEF_WIDTH-1:0] coefs,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 dout,
  output logic                             busy
);

  localparam int PROD_W = WIDTH + COEF_WIDTH;
  localparam int ACC_W  = acc_width(WIDTH, COEF_WIDTH, DEPTH);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t state;
  state_t state_nxt;

  logic [DEPTH-1:0][WIDTH-1:0]      tap_q;
  logic [DEPTH-1:0][COEF_WIDTH-1:0] coef_q;
  logic signed [ACC_W-1:0]          acc;
  logic [IDX_W-1:0]                 idx;
  logic                             acc_done;
  logic [WIDTH-1:0]                 dout_q;
  logic                             out_valid_q;

  logic signed [WIDTH-1:0]      tap_sel;
  logic signed [COEF_WIDTH-1:0] coef_sel;
  logic signed [PROD_W-1:0]     prod;
  logic [WIDTH-1:0]             rs_dout;

  // Single shared multiplier, fed from the snapshot through the idx mux
  assign tap_sel  = tap_q[idx];
  assign coef_sel = coef_q[idx];
  assign prod     = tap_sel * coef_sel;

  round_sat #(
    .ACC_W    (ACC_W),
    .WIDTH    (WIDTH),
    .FRAC_BITS(FRAC_BITS)
  ) u_round_sat (
    .acc (acc),
    .dout(rs_dout)
  );

  assign out_valid = out_valid_q;
  assign dout      = dout_q;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; in_ready and busy depend on state only
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (acc_done) state_nxt = OUT;
      end
      OUT: begin
        busy = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot, accumulate one tap per cycle, then register the rounded result and hold it in OUT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tap_q       <= '0;
      coef_q      <= '0;
      acc         <= '0;
      idx         <= '0;
      acc_done    <= 1'b0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            tap_q    <= taps;
            coef_q   <= coefs;
            acc      <= '0;
            idx      <= '0;
            acc_done <= 1'b0;
          end
        end
        MAC: begin
          if (!acc_done) begin
            acc <= acc + ACC_W'(prod);
            // idx parks at the last tap instead of wrapping; acc_done marks the sum complete
            if (idx == LAST_IDX) begin
              acc_done <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            dout_q      <= rs_dout;
            out_valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
